// File: rtl/qspi_flash_pkg.sv
// Shared types and constants for the QSPI flash responder.
package qspi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

    // How the DATA phase sources and serialises its bytes.
    typedef enum logic [1:0] {
        MODE_SINGLE,
        MODE_QUAD,
        MODE_ID
    } data_mode_t;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_QREAD = 8'h6B;
    localparam logic [7:0] OP_RDID  = 8'h9F;

    // Byte idx of the READ ID response; everything past the ID reads as 0x00.
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = id[23:16];
            2'd1:    b = id[15:8];
            2'd2:    b = id[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/qspi_flash_responder_sync.sv
// Two-flop synchronisers for the QSPI pins plus SCK edge strobes.
// SCK, CS and the data lines all see the same two-flop delay so that
// data sampled on a rise strobe belongs to that same SCK edge.
module qspi_sync_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic       ck,
    input  logic       cs,
    input  logic [3:0] io,
    output logic       cs_s,
    output logic [3:0] io_s,
    output logic       rise,
    output logic       fall
);

    logic [1:0] ck_ff;
    logic [1:0] cs_ff;
    logic [3:0] io_ff1;
    logic [3:0] io_ff2;
    logic       ck_prev;

    // Synchronise pins; CS resets deasserted so the bus looks idle out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_ff   <= 2'b00;
            cs_ff   <= 2'b11;
            io_ff1  <= 4'h0;
            io_ff2  <= 4'h0;
            ck_prev <= 1'b0;
        end else begin
            ck_ff   <= {ck_ff[0], ck};
            cs_ff   <= {cs_ff[0], cs};
            io_ff1  <= io;
            io_ff2  <= io_ff1;
            ck_prev <= ck_ff[1];
        end
    end

    assign cs_s = cs_ff[1];
    assign io_s = io_ff2;
    assign rise = ck_ff[1] & ~ck_prev;
    assign fall = ~ck_ff[1] & ck_prev;

endmodule

// File: rtl/qspi_flash_responder.sv
// Serial NOR flash responder: decodes READ / QUAD OUTPUT READ / READ ID on
// an oversampled QSPI bus and serves bytes from a backdoor-loaded array.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | CS high, nothing driven
// ST_CMD    | shifting in the 8-bit opcode on io[0]
// ST_ADDR   | shifting in the 24-bit address on io[0]
// ST_DUMMY  | counting dummy SCKs before quad data
// ST_DATA   | driving data on each fall, reloading at byte boundaries
// ST_IGNORE | unsupported opcode, wait for CS high
module qspi_flash_responder
    import qspi_flash_pkg::*;
#(
    parameter int          MEM_SZ       = 65536,
    parameter int          DUMMY_CYCLES = 8,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4018
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      qspi_ck_i,
    input  logic                      qspi_cs_i,
    input  logic [3:0]                qspi_io_i,
    input  logic [3:0]                qspi_io_t_i,
    output logic [3:0]                qspi_io_o,
    output logic [3:0]                qspi_io_oe_o,
    input  logic                      load_we_i,
    input  logic [$clog2(MEM_SZ)-1:0] load_addr_i,
    input  logic [7:0]                load_data_i,
    output logic                      busy_o,
    output logic                      cmd_err_o
);

    localparam int         AW         = $clog2(MEM_SZ);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    logic       cs_s;
    logic [3:0] io_s;
    logic       rise;
    logic       fall;

    qspi_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .ck   (qspi_ck_i),
        .cs   (qspi_cs_i),
        .io   (qspi_io_i),
        .cs_s (cs_s),
        .io_s (io_s),
        .rise (rise),
        .fall (fall)
    );

    // The master's tristate view is only of interest to an observer.
    logic unused_inputs;
    assign unused_inputs = ^{qspi_io_t_i, io_s[3:1]};

    logic [7:0] mem [MEM_SZ];

    state_t     state;
    data_mode_t mode;
    logic [7:0] cnt;
    logic [6:0] cmd_sr;
    logic [AW-1:0] addr_sr;
    logic [AW-1:0] addr;
    logic [AW-1:0] rd_addr;
    logic [7:0] shift_out;
    logic [1:0] id_idx;
    logic [7:0] opcode;
    logic [AW-1:0] addr_next;
    logic       byte_done;

    assign busy_o    = ~cs_s;
    assign opcode    = {cmd_sr, io_s[0]};
    // Only the low AW address bits survive, which gives the modulo-size wrap.
    assign addr_next = {addr_sr[AW-2:0], io_s[0]};

    // Backdoor write port; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    // Read address: the address being completed on the last ADDR rise, else the running pointer.
    always_comb begin
        rd_addr = addr;
        if (state == ST_ADDR) begin
            rd_addr = addr_next;
        end
    end

    // Last bit (single) or last nibble (quad) of the current byte goes out on this fall.
    always_comb begin
        byte_done = 1'b0;
        if (mode == MODE_QUAD) begin
            byte_done = (cnt == 8'd1);
        end else begin
            byte_done = (cnt == 8'd7);
        end
    end

    // Main sequencer: command decode, address capture and data shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            mode         <= MODE_SINGLE;
            cnt          <= 8'd0;
            cmd_sr       <= 7'd0;
            addr_sr      <= '0;
            addr         <= '0;
            shift_out    <= 8'd0;
            id_idx       <= 2'd0;
            qspi_io_o    <= 4'h0;
            qspi_io_oe_o <= 4'h0;
            cmd_err_o    <= 1'b0;
        end else begin
            cmd_err_o <= 1'b0;
            if (cs_s) begin
                state        <= ST_IDLE;
                cnt          <= 8'd0;
                qspi_io_o    <= 4'h0;
                qspi_io_oe_o <= 4'h0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_CMD;
                        cnt   <= 8'd0;
                        // Catch a rise that lands in the same cycle CS is first seen low.
                        if (rise) begin
                            cmd_sr <= opcode[6:0];
                            cnt    <= 8'd1;
                        end
                    end
                    ST_CMD: begin
                        if (rise) begin
                            cmd_sr <= opcode[6:0];
                            cnt    <= cnt + 8'd1;
                            if (cnt == 8'd7) begin
                                cnt <= 8'd0;
                                case (opcode)
                                    OP_READ: begin
                                        state <= ST_ADDR;
                                        mode  <= MODE_SINGLE;
                                    end
                                    OP_QREAD: begin
                                        state <= ST_ADDR;
                                        mode  <= MODE_QUAD;
                                    end
                                    OP_RDID: begin
                                        state     <= ST_DATA;
                                        mode      <= MODE_ID;
                                        shift_out <= id_byte(JEDEC_ID, 2'd0);
                                        id_idx    <= 2'd1;
                                    end
                                    default: begin
                                        state     <= ST_IGNORE;
                                        cmd_err_o <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (rise) begin
                            addr_sr <= addr_next;
                            cnt     <= cnt + 8'd1;
                            if (cnt == 8'd23) begin
                                cnt <= 8'd0;
                                if (mode == MODE_QUAD && DUMMY_CYCLES > 0) begin
                                    state <= ST_DUMMY;
                                    addr  <= addr_next;
                                end else begin
                                    state     <= ST_DATA;
                                    shift_out <= mem[rd_addr];
                                    addr      <= rd_addr + AW'(1);
                                end
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (rise) begin
                            cnt <= cnt + 8'd1;
                            if (cnt == DUMMY_LAST) begin
                                cnt       <= 8'd0;
                                state     <= ST_DATA;
                                shift_out <= mem[rd_addr];
                                addr      <= rd_addr + AW'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (fall) begin
                            cnt <= cnt + 8'd1;
                            if (mode == MODE_QUAD) begin
                                qspi_io_o    <= shift_out[7:4];
                                qspi_io_oe_o <= 4'hF;
                                shift_out    <= {shift_out[3:0], 4'h0};
                            end else begin
                                qspi_io_o    <= {2'b00, shift_out[7], 1'b0};
                                qspi_io_oe_o <= 4'b0010;
                                shift_out    <= {shift_out[6:0], 1'b0};
                            end
                            // Reload at the byte boundary so consecutive bytes leave no gap.
                            if (byte_done) begin
                                cnt <= 8'd0;
                                if (mode == MODE_ID) begin
                                    shift_out <= id_byte(JEDEC_ID, id_idx);
                                    if (id_idx != 2'd3) begin
                                        id_idx <= id_idx + 2'd1;
                                    end
                                end else begin
                                    shift_out <= mem[rd_addr];
                                    addr      <= rd_addr + AW'(1);
                                end
                            end
                        end
                    end
                    ST_IGNORE: begin
                        qspi_io_o    <= 4'h0;
                        qspi_io_oe_o <= 4'h0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable responder model of a serial NOR flash. It sits on the far end of the toplevel's external QSPI storage port (`external_qspi_*`) and replaces the passive stub in simulation and FPGA loopback builds. It oversamples the master's SCK and CS on the system clock, decodes read commands, and serves bytes from an internal byte array. A backdoor port preloads program images.

## Interface
- `MEM_SZ`, 65536: array size in bytes, power of two; address taken modulo `MEM_SZ`
- `DUMMY_CYCLES`, 8: SCK cycles between address and data for quad read
- `JEDEC_ID`, 24'hEF4018: bytes returned by READ ID, MSB byte first
- `clk`  in  1  system clock, at least 8× SCK frequency
- `rst`  in  1  asynchronous, active-high reset
- `qspi_ck_i`  in  1  master SCK (mode 0, CPOL=0)
- `qspi_cs_i`  in  1  master chip select, active low
- `qspi_io_i`  in  4  master-driven data lines
- `qspi_io_t_i`  in  4  master tristate, 1 = master not driving that line
- `qspi_io_o`  out  4  responder data to the master's `io_i`
- `qspi_io_oe_o`  out  4  responder drive enable per line
- `load_we_i`  in  1  backdoor byte write strobe
- `load_addr_i`  in  $clog2(MEM_SZ)  backdoor address
- `load_data_i`  in  8  backdoor data
- `busy_o`  out  1  transaction in progress (CS low as seen after sync)
- `cmd_err_o`  out  1  one-cycle pulse on an unsupported opcode

## Operation
- SCK, CS and `qspi_io_i` pass through 2-flop synchronizers with identical delay, then SCK edge detect produces `rise`/`fall` strobes.
- Sampling on `rise`; output shift on `fall`. Command and address are always single-line on `io[0]`, MSB first; address is 24 bits.
- FSM: IDLE → CMD (8 rises) → dispatch:
  - 0x03 READ: ADDR (24 rises) → DATA, 1 bit per SCK on `io[1]`, MSB first, `oe=4'b0010`.
  - 0x6B QUAD OUTPUT READ: ADDR → DUMMY (`DUMMY_CYCLES` rises) → DATA, 4 bits per SCK on `io[3:0]`, high nibble first, `oe=4'hF`.
  - 0x9F READ ID: DATA directly, single-line, shifts out `JEDEC_ID`, then repeats 0x00.
  - other: pulse `cmd_err_o`, go to IGNORE, no drive.
- DATA: byte loaded into the shift register at each byte boundary from `mem[addr]`, then addr ← (addr+1) mod `MEM_SZ`. The read wraps 0x..FFFF → 0 with no gap.
- First data bit is driven on the `fall` following the last address/dummy/command `rise`.
- Synced CS high in any state: go to IDLE next cycle, `oe=0`, `io_o=0`, and discard partial shift counts.
- Backdoor writes are accepted in any state. A write lands the next cycle. A byte already latched into the shift register is not affected.
- Reset: state IDLE, `qspi_io_o=0`, `qspi_io_oe_o=0`, `busy_o=0`, `cmd_err_o=0`. The memory array is not cleared.

## Timing
- Output update latency: 3 `clk` after the physical SCK falling edge (2 sync + 1 register). This requires an SCK half-period of ≥ 4 `clk` so data is stable before the master's next rising edge.
- `busy_o` rises 2 `clk` after physical CS falls and drops 2 `clk` after CS rises.
- `cmd_err_o` is high for exactly one `clk`, in the cycle after the 8th command `rise`.
- SCK activity while synced CS is high is ignored.
- `qspi_io_t_i` is informational only. When it reports the master driving a line the responder also drives (contention), the responder still drives; the bench flags it.

## Structure
- Package `qspi_flash_pkg`: state enum (IDLE, CMD, ADDR, DUMMY, DATA, IGNORE), opcode constants (0x03, 0x6B, 0x9F).
- Sub-module `qspi_sync_edge`: 2-flop sync for CS/SCK/io plus `rise`/`fall` strobes.
- Memory is an inferred byte array with one synchronous write port (backdoor) and one combinational read port.

## Test plan
- Reset asserted mid-DATA → all outputs 0 within one `clk`. After release, `busy_o=0` and state IDLE.
- Preload 0x000100..0x000103 = DE AD BE EF; 0x03 @ 0x000100, 32 data SCKs → `io[1]` shifts out 0xDEADBEEF MSB first; `oe=4'b0010` only during data.
- Same preload; 0x6B @ 0x000100, 8 dummy, 8 data SCKs → nibbles D,E,A,D,B,E,E,F; `oe=4'hF` only during data.
- Wrap: `mem[0xFFFF]=0x5A`, `mem[0x0000]=0xA5`; 0x03 @ 0x00FFFF for 2 bytes → 0x5A then 0xA5.
- 0x9F with 32 data SCKs → EF 40 18 00.
- Two back-to-back cases:
  - Opcode 0xAB → one `cmd_err_o` pulse and no drive.
  - CS raised after 10 address bits of 0x03 → IDLE; the next 0x03 @ 0x000100 returns 0xDE.
